// File: rtl/galaga_dl_ctrl.sv
// rtl/galaga_dl_ctrl.sv - ROM download controller: region decode, registered ROM write, core reset sequencing
module galaga_dl_ctrl #(
    parameter logic [16:0] R1_BASE   = 17'h04000,
    parameter logic [16:0] R2_BASE   = 17'h08000,
    parameter logic [16:0] R3_BASE   = 17'h0C000,
    parameter logic [16:0] TOTAL_LEN = 17'h10000,
    parameter int          HOLD_CYC  = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [16:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        rst_req,
    output logic [3:0]  rom_we,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_reset,
    output logic        dl_done,
    output logic        dl_error,
    output logic [16:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_HOLD,
        S_READY
    } state_t;

    localparam logic [15:0] HOLD_LD = 16'(HOLD_CYC);
    localparam logic [16:0] CNT_MAX = 17'h1FFFF;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_hold_cnt;
    logic        r_from_drain;
    logic [3:0]  r_rom_we;
    logic [16:0] r_rom_addr;
    logic [7:0]  r_rom_data;
    logic        r_core_reset;
    logic        r_dl_done;
    logic        r_dl_error;
    logic [16:0] r_byte_count;

    logic        w_load_entry;
    logic        w_accept;
    logic        w_in_range;
    logic        w_wr_ok;
    logic [3:0]  w_region_we;
    logic [16:0] w_region_base;

    // A write arriving with the dl_active rising edge belongs to the new download.
    assign w_load_entry = dl_active &&
                          (r_state == S_IDLE || r_state == S_HOLD || r_state == S_READY);
    assign w_accept     = dl_wr && (r_state == S_LOAD || w_load_entry);
    assign w_in_range   = (dl_addr < TOTAL_LEN);
    assign w_wr_ok      = w_accept && w_in_range;

    always_comb begin
        w_region_we   = 4'b0001;
        w_region_base = '0;
        if (dl_addr >= R3_BASE) begin
            w_region_we   = 4'b1000;
            w_region_base = R3_BASE;
        end else if (dl_addr >= R2_BASE) begin
            w_region_we   = 4'b0100;
            w_region_base = R2_BASE;
        end else if (dl_addr >= R1_BASE) begin
            w_region_we   = 4'b0010;
            w_region_base = R1_BASE;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (dl_active) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (!dl_active) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                if (dl_active)                w_next = S_LOAD;
                else if (rst_req)             w_next = S_HOLD;
                else if (r_hold_cnt <= 16'd1) w_next = S_READY;
            end
            S_READY: begin
                if (dl_active)    w_next = S_LOAD;
                else if (rst_req) w_next = S_HOLD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt   <= '0;
            r_from_drain <= 1'b0;
            r_core_reset <= 1'b1;
            r_dl_done    <= 1'b0;
        end else begin
            if (r_state == S_DRAIN) begin
                r_hold_cnt <= HOLD_LD;
            end else if ((r_state == S_HOLD || r_state == S_READY) &&
                         w_next == S_HOLD && rst_req) begin
                r_hold_cnt <= HOLD_LD;
            end else if (r_state == S_HOLD && w_next == S_LOAD) begin
                r_hold_cnt <= '0;
            end else if (r_state == S_HOLD && r_hold_cnt != 16'd0) begin
                r_hold_cnt <= r_hold_cnt - 16'd1;
            end

            // dl_done only reports the end of a download, never a plain reset request.
            if (r_state == S_DRAIN) begin
                r_from_drain <= 1'b1;
            end else if (w_load_entry || w_next == S_READY ||
                         (r_state == S_READY && w_next == S_HOLD)) begin
                r_from_drain <= 1'b0;
            end

            r_core_reset <= (w_next != S_READY);
            r_dl_done    <= (r_state == S_HOLD) && (w_next == S_READY) && r_from_drain;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_we   <= '0;
            r_rom_addr <= '0;
            r_rom_data <= '0;
        end else begin
            r_rom_we <= w_wr_ok ? w_region_we : 4'b0000;
            if (w_wr_ok) begin
                r_rom_addr <= dl_addr - w_region_base;
                r_rom_data <= dl_data;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_count <= '0;
            r_dl_error   <= 1'b0;
        end else if (w_load_entry) begin
            r_byte_count <= w_wr_ok ? 17'd1 : 17'd0;
            r_dl_error   <= w_accept && !w_in_range;
        end else if (r_state == S_LOAD) begin
            if (w_wr_ok && r_byte_count != CNT_MAX) begin
                r_byte_count <= r_byte_count + 17'd1;
            end
            if (w_accept && !w_in_range) begin
                r_dl_error <= 1'b1;
            end
        end else if (r_state == S_DRAIN) begin
            if (r_byte_count != TOTAL_LEN) begin
                r_dl_error <= 1'b1;
            end
        end
    end

    assign rom_we     = r_rom_we;
    assign rom_addr   = r_rom_addr;
    assign rom_data   = r_rom_data;
    assign core_reset = r_core_reset;
    assign dl_done    = r_dl_done;
    assign dl_error   = r_dl_error;
    assign byte_count = r_byte_count;

endmodule
